// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array result path.
//   BYTES_PER_TILE : bytes in one serialised 2x2 result tile
//   TILE_W         : width of a packed tile {c00, c01, c10, c11}
//   ELEM_W         : width of one signed result element
//   state_e        : result collector framing states
//   E_C00..E_C11   : element indices within a tile
package tpu_pkg;

  localparam int unsigned BYTES_PER_TILE = 8;
  localparam int unsigned TILE_W         = 64;
  localparam int unsigned ELEM_W         = 16;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  localparam logic [1:0] E_C00 = 2'd0;
  localparam logic [1:0] E_C01 = 2'd1;
  localparam logic [1:0] E_C10 = 2'd2;
  localparam logic [1:0] E_C11 = 2'd3;

  // c00 occupies the most significant element so the tile reads in stream order.
  function automatic logic [TILE_W-1:0] pack_tile(input logic [ELEM_W-1:0] c00,
                                                  input logic [ELEM_W-1:0] c01,
                                                  input logic [ELEM_W-1:0] c10,
                                                  input logic [ELEM_W-1:0] c11);
    return {c00, c01, c10, c11};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO, zeroes storage)
//   push       : request to enqueue push_data
//   push_data  : entry to enqueue
//   push_drop  : push refused because the FIFO is full and no pop occurs this cycle
//   head_valid : head entry available
//   pop_ready  : consumer takes the head when head_valid && pop_ready
//   head_data  : current head entry (driven from registers only)
//   count      : entries currently held, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_drop,
  output logic             head_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             empty, full, pop, accept;

  always_comb begin
    empty     = (cnt_q == '0);
    full      = (cnt_q == CNT_W'(DEPTH));
    pop       = !empty && pop_ready;
    // A pop frees the slot at the same edge, so a full FIFO can still take a push.
    accept    = push && (!full || pop);
    push_drop = push && !accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_valid = !empty;
  assign head_data  = mem_q[rd_ptr_q];
  assign count      = cnt_q;

endmodule

// File: rtl/result_collector.sv
// Reassembles the serial result byte stream of the 2x2 systolic array
// (c00.hi, c00.lo, c01.hi, ... c11.lo) into whole tiles and queues them.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : in_data carries a result byte this cycle
//   in_sof        : marks byte 0 of a tile (qualified by in_valid)
//   in_data       : result byte
//   out_valid     : head tile available
//   out_ready     : consumer accepts head tile on out_valid && out_ready
//   out_c00..c11  : head tile results (16-bit two's complement)
//   occupancy     : tiles queued, 0..DEPTH
//   err_sync      : sticky, framing lost (SOF mid-tile or missing SOF)
//   err_overflow  : sticky, completed tile dropped because the queue was full
module result_collector
  import tpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_c00,
  output logic [15:0]      out_c01,
  output logic [15:0]      out_c10,
  output logic [15:0]      out_c11,
  output logic [CNT_W-1:0] occupancy,
  output logic             err_sync,
  output logic             err_overflow
);

  state_e              state_q, state_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          hi_q, hi_d;
  logic [ELEM_W-1:0]   elem_q [4];
  logic [ELEM_W-1:0]   elem_d [4];
  logic                err_sync_q, err_sync_d;
  logic                err_overflow_q;
  logic                push, push_drop;
  logic [TILE_W-1:0]   push_tile, head_tile;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hi_d       = hi_q;
    elem_d     = elem_q;
    err_sync_d = err_sync_q;
    push       = 1'b0;
    // Last element comes straight from the incoming byte so the push lands on byte 7's edge.
    push_tile  = pack_tile(elem_q[E_C00], elem_q[E_C01], elem_q[E_C10], {hi_q, in_data});

    if (in_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (in_sof) begin
            hi_d       = in_data;
            byte_cnt_d = 3'd1;
            state_d    = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (byte_cnt_q == 3'd0 && !in_sof) begin
            // Expected the next tile's SOF; drop the byte and resynchronise.
            state_d    = ST_HUNT;
            err_sync_d = 1'b1;
          end else if (in_sof) begin
            // Restart on any SOF; only a mid-tile one is a framing error.
            if (byte_cnt_q != 3'd0) begin
              err_sync_d = 1'b1;
            end
            hi_d       = in_data;
            byte_cnt_d = 3'd1;
          end else begin
            if (!byte_cnt_q[0]) begin
              hi_d = in_data;
            end else begin
              elem_d[byte_cnt_q[2:1]] = {hi_q, in_data};
            end
            if (byte_cnt_q == 3'(BYTES_PER_TILE - 1)) begin
              push = 1'b1;
            end
            byte_cnt_d = byte_cnt_q + 1'b1;  // 7 wraps to 0, stays in COLLECT
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_HUNT;
      byte_cnt_q     <= '0;
      hi_q           <= '0;
      elem_q         <= '{default: '0};
      err_sync_q     <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      hi_q           <= hi_d;
      elem_q         <= elem_d;
      err_sync_q     <= err_sync_d;
      err_overflow_q <= err_overflow_q | push_drop;
    end
  end

  sync_fifo #(
    .WIDTH (TILE_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_tile),
    .push_drop  (push_drop),
    .head_valid (out_valid),
    .pop_ready  (out_ready),
    .head_data  (head_tile),
    .count      (occupancy)
  );

  assign {out_c00, out_c01, out_c10, out_c11} = head_tile;
  assign err_sync     = err_sync_q;
  assign err_overflow = err_overflow_q;

endmodule
